// File: rtl/irq_req_encoder.sv
// Sequential 32-to-5 request encoder: edge-captured pending bits, masked selection, valid/ack hand-off.
// Define IRQ_ENC_RR_EN for round-robin winner selection; default is fixed lowest-index priority.
module irq_req_encoder (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [31:0] req_i,
    input  logic [31:0] mask_i,
    input  logic [31:0] clr_i,
    input  logic        ack_i,
    output logic        valid_o,
    output logic [4:0]  idx_o,
    output logic [31:0] onehot_o,
    output logic [31:0] pend_o,
    output logic [0:0]  state_o
);

    // Handshake: idx_o/onehot_o are stable while valid_o=1; a cycle with
    // valid_o=1 and ack_i=1 transfers the index, ack_i is ignored otherwise.
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]  state;
    logic [31:0] req_q;
    logic [31:0] pend;
    logic [31:0] edges;
    logic [31:0] ack_clear;
    logic [31:0] cand;
    logic [31:0] pend_next;
    logic [4:0]  win;
    logic        acked;
    logic        withdraw;

    assign edges     = req_i & ~req_q;
    assign acked     = valid_o & ack_i;
    assign ack_clear = acked ? onehot_o : 32'd0;
    assign pend_next = (pend & ~clr_i & ~ack_clear) | edges;
    assign cand      = pend & mask_i;
    assign withdraw  = ~mask_i[idx_o] | clr_i[idx_o];

`ifdef IRQ_ENC_RR_EN
    logic [4:0] rr_ptr;
    logic [4:0] scan;

    // Descending scan so the bit nearest rr_ptr is the last (winning) write.
    always_comb begin
        win  = 5'd0;
        scan = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            scan = rr_ptr + 5'(k);
            if (cand[scan]) win = scan;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            rr_ptr <= 5'd0;
        end else if (state == PRESENT && ack_i) begin
            rr_ptr <= idx_o + 5'd1;
        end
    end
`else
    always_comb begin
        win = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (cand[i]) win = 5'(i);
        end
    end
`endif

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= IDLE;
            req_q    <= 32'd0;
            pend     <= 32'd0;
            valid_o  <= 1'b0;
            idx_o    <= 5'd0;
            onehot_o <= 32'd0;
        end else begin
            req_q <= req_i;
            pend  <= pend_next;
            case (state)
                IDLE: begin
                    if (cand != 32'd0) begin
                        state    <= PRESENT;
                        valid_o  <= 1'b1;
                        idx_o    <= win;
                        onehot_o <= 32'd1 << win;
                    end else begin
                        valid_o  <= 1'b0;
                        idx_o    <= 5'd0;
                        onehot_o <= 32'd0;
                    end
                end
                PRESENT: begin
                    if (ack_i || withdraw) begin
                        state    <= IDLE;
                        valid_o  <= 1'b0;
                        idx_o    <= 5'd0;
                        onehot_o <= 32'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    valid_o  <= 1'b0;
                    idx_o    <= 5'd0;
                    onehot_o <= 32'd0;
                end
            endcase
        end
    end

    assign pend_o  = pend;
    assign state_o = state;

endmodule

// File: tb/tb_irq_req_encoder.sv
// Bench for irq_req_encoder: directed vector tables, async-reset check, randomized run against a model.
// Follows IRQ_ENC_RR_EN to pick the selection rule of the reference model.
module tb_irq_req_encoder;

    typedef struct {
        logic [31:0] req;
        logic [31:0] mask;
        logic [31:0] clr;
        logic        ack;
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] pend;
    } vec_t;

`ifdef IRQ_ENC_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif
    localparam logic [31:0] ALL = 32'hffff_ffff;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic [31:0] mask;
    logic [31:0] clr;
    logic        ack;
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] onehot;
    logic [31:0] pend;
    logic [0:0]  state;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_pend;
    logic [31:0] m_req_q;
    logic        m_valid;
    int          m_idx;
    int          m_rr;

    vec_t tbl[$];

    irq_req_encoder dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .req_i       (req),
        .mask_i      (mask),
        .clr_i       (clr),
        .ack_i       (ack),
        .valid_o     (valid),
        .idx_o       (idx),
        .onehot_o    (onehot),
        .pend_o      (pend),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = 32'd0;
        m_req_q = 32'd0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_rr    = 0;
    endtask

    // One clock of the rules: capture rising edges, clear on clr/ack unless re-set,
    // then either hold/drop the current grant or choose a new one from pending&mask.
    task automatic model_tick();
        logic [31:0] nxt;
        bit keep;
        int start;
        int w;
        int i;
        nxt = 32'd0;
        for (int b = 0; b < 32; b++) begin
            keep = m_pend[b] && !clr[b] && !(m_valid && ack && b == m_idx);
            nxt[b] = keep || (req[b] && !m_req_q[b]);
        end
        if (m_valid) begin
            if (ack) begin
                m_rr    = (m_idx + 1) % 32;
                m_valid = 1'b0;
                m_idx   = 0;
            end else if (!mask[m_idx] || clr[m_idx]) begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end else begin
            w = -1;
            start = RR_MODE ? m_rr : 0;
            for (int k = 0; k < 32; k++) begin
                i = (start + k) % 32;
                if (w < 0 && m_pend[i] && mask[i]) w = i;
            end
            if (w >= 0) begin
                m_valid = 1'b1;
                m_idx   = w;
            end
        end
        m_pend  = nxt;
        m_req_q = req;
    endtask

    task automatic step(input logic [31:0] r, input logic [31:0] m, input logic [31:0] c, input logic a);
        req  = r;
        mask = m;
        clr  = c;
        ack  = a;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic add_row(input logic [31:0] r, input logic [31:0] m, input logic [31:0] c,
                           input logic a, input logic v, input logic [4:0] i, input logic [31:0] p);
        vec_t row;
        row.req = r; row.mask = m; row.clr = c; row.ack = a;
        row.valid = v; row.idx = i; row.pend = p;
        tbl.push_back(row);
    endtask

    task automatic run_table(input string tag);
        logic [31:0] exp_oh;
        foreach (tbl[k]) begin
            step(tbl[k].req, tbl[k].mask, tbl[k].clr, tbl[k].ack);
            exp_oh = tbl[k].valid ? (32'd1 << tbl[k].idx) : 32'd0;
            check($sformatf("%s[%0d].valid", tag, k), {31'd0, valid}, {31'd0, tbl[k].valid});
            check($sformatf("%s[%0d].idx", tag, k), {27'd0, idx}, {27'd0, tbl[k].idx});
            check($sformatf("%s[%0d].onehot", tag, k), onehot, exp_oh);
            check($sformatf("%s[%0d].pend", tag, k), pend, tbl[k].pend);
        end
        tbl.delete();
    endtask

    task automatic do_reset(input logic [31:0] r);
        rst_n = 1'b0;
        req = r; mask = ALL; clr = 32'd0; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        do_reset(32'h0000_0001);
        check("rst.valid", {31'd0, valid}, 32'd0);
        check("rst.idx", {27'd0, idx}, 32'd0);
        check("rst.onehot", onehot, 32'd0);
        check("rst.pend", pend, 32'd0);
        check("rst.state", {31'd0, state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset release, priority, withdraw, simultaneous events, stray ack
        add_row(32'h1, ALL, 0, 0, 0, 0, 32'h1);
        add_row(32'h1, ALL, 0, 0, 1, 0, 32'h1);
        add_row(32'h1, ALL, 0, 1, 0, 0, 32'h0);
        add_row(32'h0, ALL, 0, 0, 0, 0, 32'h0);
        add_row(32'h0002_0020, ALL, 0, 0, 0, 0, 32'h0002_0020);
        add_row(32'h0002_0020, ALL, 0, 0, 1, 5, 32'h0002_0020);
        add_row(32'h0002_0020, ALL, 0, 1, 0, 0, 32'h0002_0000);
        add_row(32'h0002_0020, ALL, 0, 0, 1, 17, 32'h0002_0000);
        add_row(32'h0002_0020, ALL, 0, 1, 0, 0, 32'h0);
        add_row(32'h0, ALL, 0, 0, 0, 0, 32'h0);
        add_row(32'h200, ALL, 0, 0, 0, 0, 32'h200);
        add_row(32'h200, ALL, 0, 0, 1, 9, 32'h200);
        add_row(32'h200, ~32'h200, 0, 0, 0, 0, 32'h200);
        add_row(32'h200, ~32'h200, 0, 0, 0, 0, 32'h200);
        add_row(32'h200, ALL, 0, 0, 1, 9, 32'h200);
        add_row(32'h0, ALL, 0, 1, 0, 0, 32'h0);
        add_row(32'h10, ALL, 0, 0, 0, 0, 32'h10);
        add_row(32'h0, ALL, 0, 0, 1, 4, 32'h10);
        add_row(32'h10, ALL, 0, 1, 0, 0, 32'h10);
        add_row(32'h10, ALL, 0, 0, 1, 4, 32'h10);
        add_row(32'h0, ALL, 0, 0, 1, 4, 32'h10);
        add_row(32'h10, ALL, 32'h10, 0, 0, 0, 32'h10);
        add_row(32'h10, ALL, 0, 0, 1, 4, 32'h10);
        add_row(32'h10, ALL, 0, 1, 0, 0, 32'h0);
        add_row(32'h100, 32'h0, 0, 0, 0, 0, 32'h100);
        add_row(32'h100, 32'h0, 0, 1, 0, 0, 32'h100);
        add_row(32'h100, 32'h0, 0, 1, 0, 0, 32'h100);
        add_row(32'h100, 32'h0, 32'h100, 0, 0, 0, 32'h0);
        run_table("dir");

        // asynchronous reset in the middle of a presentation
        step(32'h80, ALL, 0, 0);
        step(32'h80, ALL, 0, 0);
        check("mid.valid", {31'd0, valid}, 32'd1);
        check("mid.idx", {27'd0, idx}, 32'd7);
        #5;
        rst_n = 1'b0;
        #1;
        check("arst.valid", {31'd0, valid}, 32'd0);
        check("arst.onehot", onehot, 32'd0);
        check("arst.pend", pend, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        add_row(32'h80, ALL, 0, 0, 0, 0, 32'h80);
        add_row(32'h80, ALL, 0, 0, 1, 7, 32'h80);
        add_row(32'h0, ALL, 0, 1, 0, 0, 32'h0);
        run_table("arst");

`ifdef IRQ_ENC_RR_EN
        do_reset(32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        add_row(32'h8000_0009, ALL, 0, 0, 0, 0, 32'h8000_0009);
        add_row(32'h8000_0009, ALL, 0, 0, 1, 0, 32'h8000_0009);
        add_row(32'h8000_0009, ALL, 0, 1, 0, 0, 32'h8000_0008);
        add_row(32'h8000_0009, ALL, 0, 0, 1, 3, 32'h8000_0008);
        add_row(32'h8000_0009, ALL, 0, 1, 0, 0, 32'h8000_0000);
        add_row(32'h8000_0009, ALL, 0, 0, 1, 31, 32'h8000_0000);
        add_row(32'h8000_0009, ALL, 0, 1, 0, 0, 32'h0);
        add_row(32'h0, ALL, 0, 0, 0, 0, 32'h0);
        add_row(32'h8000_0002, ALL, 0, 0, 0, 0, 32'h8000_0002);
        add_row(32'h8000_0002, ALL, 0, 0, 1, 1, 32'h8000_0002);
        run_table("rr");
`endif

        // randomized traffic against the model
        do_reset(32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r, m, c;
            logic a;
            r = $urandom() & $urandom() & $urandom();
            m = ($urandom_range(0, 3) == 0) ? $urandom() : ALL;
            c = ($urandom_range(0, 7) == 0) ? ($urandom() & $urandom() & $urandom()) : 32'd0;
            a = ($urandom_range(0, 2) != 0);
            step(r, m, c, a);
            check($sformatf("rnd[%0d].valid", n), {31'd0, valid}, {31'd0, m_valid});
            check($sformatf("rnd[%0d].idx", n), {27'd0, idx}, 32'(m_idx));
            check($sformatf("rnd[%0d].onehot", n), onehot, m_valid ? (32'd1 << m_idx) : 32'd0);
            check($sformatf("rnd[%0d].pend", n), pend, m_pend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
